alu_pipe: RTL

- Parametrised, handshaked successor to the 4-bit combinational ALU. Keeps the 4-bit opcode space and the 6-bit flag vector.
- Adds the following:
  - a registered output stage with valid/ready on both sides;
  - a sticky carry register for multi-word ADDC/SUBB chains;
  - an iterative multi-cycle multiply.
- Sits between the operand fetch logic and the writeback logic of the datapath.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_pipe_if.sv | 25 ++
 rtl/alu_mul_iter.sv | 50 +++++
 rtl/alu_pipe.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pipe shared types: opcodes, flag bit indices and FSM states.
// Imported by alu_pipe and alu_mul_iter.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_NOR   = 4'h5,
    OP_SLL   = 4'h6,
    OP_SRL   = 4'h7,
    OP_SRA   = 4'h8,
    OP_SLT   = 4'h9,
    OP_SLTU  = 4'hA,
    OP_ADDC  = 4'hB,
    OP_SUBB  = 4'hC,
    OP_MUL   = 4'hD,
    OP_PASSA = 4'hE,
    OP_PASSB = 4'hF
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_P = 4;
  localparam int FLAG_E = 5;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe handshake bundle: operand side (in_valid/in_ready, a, b,
// alu_control) and result side (out_valid/out_ready, y, flag).
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [5:0]       flag;

  modport master (
    output in_valid, a, b, alu_control, out_ready,
    input  in_ready, out_valid, y, flag
  );

  modport slave (
    input  in_valid, a, b, alu_control, out_ready,
    output in_ready, out_valid, y, flag
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: start latches a/b, then one partial
// product per cycle; done/product are valid during the last iteration.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  // product is the accumulator after this cycle's step, so the
  // caller can capture it on the same edge that finishes the run
  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product = acc_d;
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered output, sticky carry and iterative MUL.
// Ports: clk, rst_n (sync, active-low), bus (alu_pipe_if.slave).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_pipe: WIDTH must be a power of two >= 4");
  end

  state_e             state_q, state_d;
  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [5:0]         flag_q, flag_d;
  logic               carry_q, carry_d;
  logic               eq_q, eq_d;

  alu_op_e            op;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;

  logic [SHW-1:0]     sh;
  logic               sub;
  logic [WIDTH-1:0]   opnd;
  logic               cin;
  logic [WIDTH:0]     sum, sll, srl, sra;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v, wr_carry;

  logic               ld;
  logic [WIDTH-1:0]   ld_y;
  logic               ld_c, ld_v, ld_e;

  assign op           = alu_op_e'(bus.alu_control);
  assign bus.in_ready = rst_n && (state_q == IDLE)
                        && (!vld_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (op == OP_MUL);
  assign bus.out_valid = vld_q;
  assign bus.y         = y_q;
  assign bus.flag      = flag_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (prod)
  );

  // One adder serves ADD/SUB/ADDC/SUBB; C out of a+~b+1 is no-borrow.
  // Shifts run one bit wider so the last bit out lands in the spare bit.
  always_comb begin
    sh   = bus.b[SHW-1:0];
    sub  = (op == OP_SUB) || (op == OP_SUBB);
    opnd = sub ? ~bus.b : bus.b;
    cin  = (op == OP_ADDC || op == OP_SUBB) ? carry_q
                                            : (op == OP_SUB);
    sum  = {1'b0, bus.a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
    sll  = {1'b0, bus.a} << sh;
    srl  = {bus.a, 1'b0} >> sh;
    sra  = $unsigned($signed({bus.a, 1'b0}) >>> sh);
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    wr_carry = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_ADDC, OP_SUBB: begin
        res      = sum[WIDTH-1:0];
        res_c    = sum[WIDTH];
        res_v    = (bus.a[WIDTH-1] == opnd[WIDTH-1])
                   && (sum[WIDTH-1] != bus.a[WIDTH-1]);
        wr_carry = 1'b1;
      end
      OP_AND:   res = bus.a & bus.b;
      OP_OR:    res = bus.a | bus.b;
      OP_XOR:   res = bus.a ^ bus.b;
      OP_NOR:   res = ~(bus.a | bus.b);
      OP_SLL: begin
        res   = sll[WIDTH-1:0];
        res_c = sll[WIDTH];
      end
      OP_SRL: begin
        res   = srl[WIDTH:1];
        res_c = srl[0];
      end
      OP_SRA: begin
        res   = sra[WIDTH:1];
        res_c = sra[0];
      end
      OP_SLT:   res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLTU:  res = WIDTH'(bus.a < bus.b);
      OP_MUL:   res = '0;
      OP_PASSA: res = bus.a;
      OP_PASSB: res = bus.b;
    endcase
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q && !bus.out_ready;
    y_d     = y_q;
    flag_d  = flag_q;
    carry_d = carry_q;
    eq_d    = eq_q;
    ld      = 1'b0;
    ld_y    = res;
    ld_c    = res_c;
    ld_v    = res_v;
    ld_e    = (bus.a == bus.b);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          eq_d = ld_e;
          if (op == OP_MUL) begin
            state_d = MUL;
          end else begin
            ld = 1'b1;
            if (wr_carry) carry_d = res_c;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          ld      = 1'b1;
          ld_y    = prod[WIDTH-1:0];
          ld_c    = |prod[2*WIDTH-1:WIDTH];
          ld_v    = 1'b0;
          ld_e    = eq_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      vld_d          = 1'b1;
      y_d            = ld_y;
      flag_d[FLAG_Z] = (ld_y == '0);
      flag_d[FLAG_N] = ld_y[WIDTH-1];
      flag_d[FLAG_C] = ld_c;
      flag_d[FLAG_V] = ld_v;
      flag_d[FLAG_P] = ^ld_y;
      flag_d[FLAG_E] = ld_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      y_q     <= '0;
      flag_q  <= '0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      y_q     <= y_d;
      flag_q  <= flag_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
    end
  end
endmodule
